control_unit_pipe: RTL and testbench
====================================

// Module: control_unit_pipe
// PURPOSE
//  Parametrised, registered successor to the ID-stage control decoder. Decodes {mode,opcode,s} into
//  EXE/MEM/WB control and gates it with ARM condition check against NZCV. Carries the result through
//  DEPTH register stages with freeze/flush. Squashes a configurable branch shadow after a taken branch.
//  Sits between instruction decode and the ID/EX boundary.
// PARAMETERS
//  DEPTH      1   register stages between decode and outputs (1..4); latency = DEPTH cycles
//  SHADOW     1   accepted instructions squashed after a taken branch (0..7)
//  EXEC_W     4   exec_command width
//  MODE_W     2   mode width
//  OPCODE_W   4   opcode width
// PORTS
//  clk                  in   1         clock, rising edge
//  rst                  in   1         synchronous, active-high reset
//  in_valid             in   1         decode inputs valid this cycle
//  mode                 in   MODE_W    00 data-proc, 01 memory, 10 branch, 11 illegal
//  opcode               in   OPCODE_W  ARM data-proc opcode
//  s                    in   1         S bit (memory mode: 1=LDR, 0=STR)
//  cond                 in   4         ARM condition field
//  status               in   4         {N,Z,C,V}, sampled with the instruction
//  freeze               in   1         hold all stages and shadow counter
//  flush                in   1         invalidate all stages and clear shadow counter
//  out_valid            out  1         outputs below describe a live instruction
//  exec_command         out  EXEC_W    ALU command
//  mem_read, mem_write  out  1 each    memory enables
//  wb_enable            out  1         register write-back
//  branch               out  1         taken branch
//  status_write_enable  out  1         update NZCV
//  illegal              out  1         valid instruction with undefined encoding
// BEHAVIOUR
//  - Reset: every stage valid=0, all outputs 0, shadow counter 0. Reset overrides flush and freeze.
//  - Decode, mode 00:
//    MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100,
//    SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000.
//    All of these set wb=1 and status_we=s.
//    CMP 1010->0100 and TST 1000->0110 set wb=0 and status_we=1.
//    Any other opcode raises illegal.
//  - Decode, mode 01: opcode 0100 only, exec 0010. s=1 gives mem_read=1, wb=1; s=0 gives mem_write=1.
//    Any other opcode raises illegal.
//  - Decode, mode 10: branch=1, exec 0000 (don't-care, driven 0). Mode 11 raises illegal.
//  - Condition check: EQ..LE per ARM on {N,Z,C,V}; AL(1110) passes; 1111 fails.
//    Fail or illegal forces exec_command and all enables to 0; valid is kept.
//    illegal=1 only when the cond passes.
//  - Stage 0 loads when in_valid & ~freeze & ~flush. A squashed or invalid input loads valid=0.
//    Stage k loads from stage k-1. out_* equal the last stage; out_valid=0 forces every output to 0.
//  - freeze=1: all stages and the counter hold.
//  - flush=1: all stages get valid=0 and the counter is cleared next edge. flush wins over freeze.
//  - Shadow: when a taken branch is loaded into stage 0, the counter is set to SHADOW.
//    While counter>0, each accepted in_valid is loaded as invalid and the counter decrements.
//    A branch arriving in the shadow is squashed and does not reload the counter.
//    SHADOW=0 disables the shadow.
//  - Counter saturates at 0 (no wrap). in_valid=0 cycles do not decrement.
// STRUCTURE
//  - arm_ctrl_pkg (shared package): MODE_*, OP_* and EXE_* encodings, COND_* codes, NZCV bit indices,
//    and a ctrl_t bundle {valid, exec, mem_r, mem_w, wb, br, swe, illegal}.
//  - One sub-module: cond_check (cond[3:0], status[3:0] -> pass). Purely combinational and reused by EXE.
//  - Decoder is a combinational always block, followed by a generate loop of DEPTH ctrl_t registers
//    and the shadow counter register.
// TESTING
//  1. DEPTH=2: ADD s=1, cond=1110 -> after 2 cycles out_valid=1, exec=0010, wb=1, status_we=1.
//  2. CMP with cond=0000, status=0000 (Z=0) -> out_valid=1, exec=0, all enables 0, illegal=0.
//  3. LDR then STR -> mem_read=1, wb=1 on the first; mem_write=1, wb=0 on the second; exec=0010 both.
//  4. SHADOW=1: taken B, ADD, SUB back-to-back -> B out, ADD slot out_valid=0, SUB out_valid=1.
//  5. freeze held 3 cycles with flush asserted on cycle 2 -> pipeline empty, counter 0, flush wins.
//  6. mode=01 opcode=0010 and mode=11 -> illegal=1, all enables 0; rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM-subset control path: modes, opcodes, ALU commands,
// condition codes, NZCV bit positions and the per-stage control bundle.
package arm_ctrl_pkg;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_EOR  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADC  = 4'b0101;
    localparam logic [3:0] OP_SBC  = 4'b0110;
    localparam logic [3:0] OP_TST  = 4'b1000;
    localparam logic [3:0] OP_CMP  = 4'b1010;
    localparam logic [3:0] OP_ORR  = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_MVN  = 4'b1111;
    localparam logic [3:0] OP_LDST = 4'b0100;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef struct packed {
        logic       valid;
        logic [3:0] exec;
        logic       mem_r;
        logic       mem_w;
        logic       wb;
        logic       br;
        logic       swe;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/control_unit_pipe_cond_check.sv
// ARM condition evaluation against {N,Z,C,V}; combinational so the EXE stage can reuse it.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       pass
);

    logic n, z, c, v;

    assign n = status[NZCV_N];
    assign z = status[NZCV_Z];
    assign c = status[NZCV_C];
    assign v = status[NZCV_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit_pipe.sv
// Registered ID-stage control decoder: decode, condition gating, DEPTH-stage pipe with
// freeze/flush, and branch-shadow squashing.
module control_unit_pipe
    import arm_ctrl_pkg::*;
#(
    parameter int DEPTH    = 1,
    parameter int SHADOW   = 1,
    parameter int EXEC_W   = 4,
    parameter int MODE_W   = 2,
    parameter int OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [MODE_W-1:0]   mode,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                s,
    input  logic [3:0]          cond,
    input  logic [3:0]          status,
    input  logic                freeze,
    input  logic                flush,
    output logic                out_valid,
    output logic [EXEC_W-1:0]   exec_command,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_enable,
    output logic                branch,
    output logic                status_write_enable,
    output logic                illegal
);

    localparam int CNT_W = 3;

    logic [1:0]       mode_f;
    logic [3:0]       op_f;
    logic             pass;
    logic             squash;
    logic [CNT_W-1:0] shadow_cnt;
    ctrl_t            raw_c;
    ctrl_t            dec_c;
    ctrl_t            stage_in [DEPTH];
    ctrl_t            ctrl_p   [DEPTH];
    ctrl_t            last;

    assign mode_f = 2'(mode);
    assign op_f   = 4'(opcode);
    assign squash = (shadow_cnt != '0);

    cond_check u_cond_check (
        .cond   (cond),
        .status (status),
        .pass   (pass)
    );

    always_comb begin
        raw_c = '0;
        case (mode_f)
            MODE_DP: begin
                raw_c.wb  = 1'b1;
                raw_c.swe = s;
                case (op_f)
                    OP_MOV:  raw_c.exec = EXE_MOV;
                    OP_MVN:  raw_c.exec = EXE_MVN;
                    OP_ADD:  raw_c.exec = EXE_ADD;
                    OP_ADC:  raw_c.exec = EXE_ADC;
                    OP_SUB:  raw_c.exec = EXE_SUB;
                    OP_SBC:  raw_c.exec = EXE_SBC;
                    OP_AND:  raw_c.exec = EXE_AND;
                    OP_ORR:  raw_c.exec = EXE_ORR;
                    OP_EOR:  raw_c.exec = EXE_EOR;
                    OP_CMP: begin
                        raw_c.exec = EXE_SUB;
                        raw_c.wb   = 1'b0;
                        raw_c.swe  = 1'b1;
                    end
                    OP_TST: begin
                        raw_c.exec = EXE_AND;
                        raw_c.wb   = 1'b0;
                        raw_c.swe  = 1'b1;
                    end
                    default: begin
                        raw_c.wb      = 1'b0;
                        raw_c.swe     = 1'b0;
                        raw_c.illegal = 1'b1;
                    end
                endcase
            end
            MODE_MEM: begin
                if (op_f == OP_LDST) begin
                    raw_c.exec  = EXE_ADD;
                    raw_c.mem_r = s;
                    raw_c.mem_w = ~s;
                    raw_c.wb    = s;
                end else begin
                    raw_c.illegal = 1'b1;
                end
            end
            MODE_BR:  raw_c.br      = 1'b1;
            default:  raw_c.illegal = 1'b1;
        endcase
    end

    // Condition failure or undefined encoding kills every enable but keeps the slot valid.
    always_comb begin
        dec_c         = '0;
        dec_c.valid   = in_valid & ~squash;
        dec_c.illegal = raw_c.illegal & pass;
        if (pass && !raw_c.illegal) begin
            dec_c.exec  = raw_c.exec;
            dec_c.mem_r = raw_c.mem_r;
            dec_c.mem_w = raw_c.mem_w;
            dec_c.wb    = raw_c.wb;
            dec_c.br    = raw_c.br;
            dec_c.swe   = raw_c.swe;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_in[k] = dec_c;
        end else begin : g_next
            assign stage_in[k] = ctrl_p[k-1];
        end

        // Only the valid bit is reset; payload is ignored while invalid.
        always_ff @(posedge clk) begin
            if (rst) begin
                ctrl_p[k].valid <= 1'b0;
            end else if (flush) begin
                ctrl_p[k].valid <= 1'b0;
            end else if (!freeze) begin
                ctrl_p[k] <= stage_in[k];
            end
        end
    end

    // Counter only reloads from an unsquashed branch, so a branch in the shadow cannot extend it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            shadow_cnt <= '0;
        end else if (!freeze && in_valid) begin
            if (squash) begin
                shadow_cnt <= shadow_cnt - 1'b1;
            end else if (dec_c.br) begin
                shadow_cnt <= CNT_W'(SHADOW);
            end
        end
    end

    assign last = ctrl_p[DEPTH-1];

    always_comb begin
        out_valid           = last.valid;
        exec_command        = '0;
        mem_read            = 1'b0;
        mem_write           = 1'b0;
        wb_enable           = 1'b0;
        branch              = 1'b0;
        status_write_enable = 1'b0;
        illegal             = 1'b0;
        if (last.valid) begin
            exec_command        = EXEC_W'(last.exec);
            mem_read            = last.mem_r;
            mem_write           = last.mem_w;
            wb_enable           = last.wb;
            branch              = last.br;
            status_write_enable = last.swe;
            illegal             = last.illegal;
        end
    end

endmodule

// File: tb/tb_control_unit_pipe.sv
// Scoreboard bench for control_unit_pipe with DEPTH=2, SHADOW=1: an independent decode
// model feeds a DEPTH-deep expectation queue that is compared each cycle.
module tb_control_unit_pipe;

    localparam int DEPTH  = 2;
    localparam int SHADOW = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] opcode = 4'h0;
    logic       s = 1'b0;
    logic [3:0] cond = 4'hE;
    logic [3:0] status = 4'h0;
    logic       freeze = 1'b0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic [3:0] exec_command;
    logic       mem_read, mem_write, wb_enable, branch, status_write_enable, illegal;

    typedef struct packed {
        logic       v;
        logic [3:0] ex;
        logic       mr;
        logic       mw;
        logic       wb;
        logic       br;
        logic       swe;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_m  = 0;

    always #5 clk = ~clk;

    control_unit_pipe #(
        .DEPTH(DEPTH), .SHADOW(SHADOW), .EXEC_W(4), .MODE_W(2), .OPCODE_W(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .opcode(opcode), .s(s),
        .cond(cond), .status(status), .freeze(freeze), .flush(flush),
        .out_valid(out_valid), .exec_command(exec_command), .mem_read(mem_read),
        .mem_write(mem_write), .wb_enable(wb_enable), .branch(branch),
        .status_write_enable(status_write_enable), .illegal(illegal)
    );

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cc;
            4'h3: return !cc;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cc && !z;
            4'h9: return !cc || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input logic [1:0] m, input logic [3:0] op, input logic ss,
                                   input logic [3:0] c, input logic [3:0] st);
        exp_t       e;
        logic       bad, p, mr, mw, wb, br, swe;
        logic [3:0] ex;
        e = '0; bad = 1'b0; ex = 4'h0; mr = 1'b0; mw = 1'b0; wb = 1'b0; br = 1'b0; swe = 1'b0;
        p = cond_ok(c, st);
        if (m == 2'b00) begin
            wb = 1'b1; swe = ss;
            case (op)
                4'hD: ex = 4'h1;
                4'hF: ex = 4'h9;
                4'h4: ex = 4'h2;
                4'h5: ex = 4'h3;
                4'h2: ex = 4'h4;
                4'h6: ex = 4'h5;
                4'h0: ex = 4'h6;
                4'hC: ex = 4'h7;
                4'h1: ex = 4'h8;
                4'hA: begin ex = 4'h4; wb = 1'b0; swe = 1'b1; end
                4'h8: begin ex = 4'h6; wb = 1'b0; swe = 1'b1; end
                default: bad = 1'b1;
            endcase
        end else if (m == 2'b01) begin
            if (op == 4'h4) begin ex = 4'h2; mr = ss; mw = !ss; wb = ss; swe = 1'b0; end
            else bad = 1'b1;
        end else if (m == 2'b10) begin
            br = 1'b1;
        end else begin
            bad = 1'b1;
        end
        e.v = 1'b1;
        if (p && !bad) begin
            e.ex = ex; e.mr = mr; e.mw = mw; e.wb = wb; e.br = br; e.swe = swe;
        end
        e.ill = bad && p;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        e = exp_q[0];
        chk({tag, ".out_valid"}, {3'b0, out_valid}, {3'b0, e.v});
        chk({tag, ".exec"}, exec_command, e.ex);
        chk({tag, ".mem_read"}, {3'b0, mem_read}, {3'b0, e.mr});
        chk({tag, ".mem_write"}, {3'b0, mem_write}, {3'b0, e.mw});
        chk({tag, ".wb"}, {3'b0, wb_enable}, {3'b0, e.wb});
        chk({tag, ".branch"}, {3'b0, branch}, {3'b0, e.br});
        chk({tag, ".swe"}, {3'b0, status_write_enable}, {3'b0, e.swe});
        chk({tag, ".illegal"}, {3'b0, illegal}, {3'b0, e.ill});
    endtask

    task automatic step(input string tag, input logic iv, input logic [1:0] m, input logic [3:0] op,
                        input logic ss, input logic [3:0] c, input logic [3:0] st,
                        input logic fz, input logic fl, input logic rs);
        exp_t e;
        in_valid = iv; mode = m; opcode = op; s = ss; cond = c; status = st;
        freeze = fz; flush = fl; rst = rs;
        e = model(m, op, ss, c, st);
        @(posedge clk);
        if (rs || fl) begin
            for (int i = 0; i < DEPTH; i++) exp_q[i] = '0;
            cnt_m = 0;
        end else if (!fz) begin
            if (!iv) begin
                e = '0;
            end else if (cnt_m > 0) begin
                e = '0;
                cnt_m--;
            end else if (e.br) begin
                cnt_m = SHADOW;
            end
            void'(exp_q.pop_front());
            exp_q.push_back(e);
        end
        #1;
        compare_out(tag);
    endtask

    task automatic issue(input string tag, input logic [1:0] m, input logic [3:0] op,
                         input logic ss, input logic [3:0] c, input logic [3:0] st);
        step(tag, 1'b1, m, op, ss, c, st, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 2'b00, 4'h0, 1'b0, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('0);

        step("reset0", 1'b1, 2'b00, 4'h4, 1'b1, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1);
        step("reset1", 1'b1, 2'b00, 4'h4, 1'b1, 4'hE, 4'h0, 1'b1, 1'b1, 1'b1);

        issue("add_s", 2'b00, 4'h4, 1'b1, 4'hE, 4'h0);
        idle("add_lat1");
        idle("add_out");

        issue("cmp_eq_fail", 2'b00, 4'hA, 1'b0, 4'h0, 4'h0);
        issue("cmp_eq_pass", 2'b00, 4'hA, 1'b0, 4'h0, 4'h4);
        issue("ldr", 2'b01, 4'h4, 1'b1, 4'hE, 4'h0);
        issue("str", 2'b01, 4'h4, 1'b0, 4'hE, 4'h0);
        idle("mem_drain0");
        idle("mem_drain1");

        for (int op = 0; op < 16; op++)
            issue("dp_table", 2'b00, 4'(op), 1'(op % 2), 4'hE, 4'h0);
        for (int c = 0; c < 16; c++) begin
            issue("cond_sweep", 2'b00, 4'hD, 1'b1, 4'(c), 4'($urandom_range(0, 15)));
            issue("cond_sweep", 2'b00, 4'h1, 1'b0, 4'(c), 4'(c ^ 4'h5));
        end

        issue("br_taken", 2'b10, 4'h0, 1'b0, 4'hE, 4'h0);
        issue("br_shadow_add", 2'b00, 4'h4, 1'b0, 4'hE, 4'h0);
        issue("br_after_sub", 2'b00, 4'h2, 1'b0, 4'hE, 4'h0);
        issue("br_not_taken", 2'b10, 4'h0, 1'b0, 4'h1, 4'h4);
        issue("nt_next_add", 2'b00, 4'h4, 1'b0, 4'hE, 4'h0);
        issue("br_a", 2'b10, 4'h0, 1'b0, 4'hE, 4'h0);
        issue("br_in_shadow", 2'b10, 4'h0, 1'b0, 4'hE, 4'h0);
        issue("after_sq_br", 2'b00, 4'hC, 1'b1, 4'hE, 4'h0);
        issue("br_b", 2'b10, 4'h0, 1'b0, 4'hE, 4'h0);
        idle("shadow_bubble");
        issue("shadow_after_bubble", 2'b00, 4'h4, 1'b0, 4'hE, 4'h0);
        issue("post_shadow", 2'b00, 4'h2, 1'b0, 4'hE, 4'h0);

        issue("pre_frz_add", 2'b00, 4'h4, 1'b0, 4'hE, 4'h0);
        issue("pre_frz_br", 2'b10, 4'h0, 1'b0, 4'hE, 4'h0);
        step("freeze1", 1'b1, 2'b00, 4'h2, 1'b0, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0);
        step("freeze2_flush", 1'b1, 2'b00, 4'h2, 1'b0, 4'hE, 4'h0, 1'b1, 1'b1, 1'b0);
        step("freeze3", 1'b1, 2'b00, 4'h2, 1'b0, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0);
        issue("post_flush_add", 2'b00, 4'h4, 1'b0, 4'hE, 4'h0);
        idle("post_flush_drain0");
        idle("post_flush_drain1");

        issue("br_before_frz", 2'b10, 4'h0, 1'b0, 4'hE, 4'h0);
        step("frz_in_shadow", 1'b1, 2'b00, 4'h4, 1'b0, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0);
        issue("shadow_after_frz", 2'b00, 4'h4, 1'b0, 4'hE, 4'h0);
        issue("after_shadow_frz", 2'b00, 4'h5, 1'b1, 4'hE, 4'h0);

        issue("mem_bad_op", 2'b01, 4'h2, 1'b1, 4'hE, 4'h0);
        issue("mode11", 2'b11, 4'h4, 1'b1, 4'hE, 4'h0);
        issue("mode11_condfail", 2'b11, 4'h4, 1'b1, 4'hF, 4'h0);
        issue("pre_rst_add", 2'b00, 4'h4, 1'b1, 4'hE, 4'h0);
        step("mid_rst", 1'b1, 2'b00, 4'h4, 1'b1, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1);
        issue("post_rst_mov", 2'b00, 4'hD, 1'b0, 4'hE, 4'h0);
        idle("final_drain0");
        idle("final_drain1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
